// File: rtl/ql_pl_pkg.sv
// Shared types and constants for the RAM PL side-port initiator.
// Holds the FSM state encoding, default PL widths and a request record.
package ql_pl_pkg;

   localparam int PL_ADDR_W = 20;
   localparam int PL_DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      RWAIT = 3'd3,
      RESP  = 3'd4,
      SWEEP = 3'd5
   } pl_state_t;

   typedef struct packed {
      logic                 we;
      logic [PL_ADDR_W-1:0] addr;
      logic [PL_DATA_W-1:0] wdata;
   } pl_req_t;

   // Width of the shared counter: must hold SWEEP_DEPTH-1 and RD_LAT-2.
   function automatic int pl_cnt_w(input int depth, input int lat);
      int m;
      m = (depth > lat) ? depth : lat;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/ram_pl_master.sv
// Initiator for the RAM macro PL port: single-word reads/writes over valid/ready
// plus a self-timed fill sweep with PL_INIT, all outputs driven from flops.
module ram_pl_master
   import ql_pl_pkg::*;
#(
   parameter int ADDR_W      = PL_ADDR_W,
   parameter int DATA_W      = PL_DATA_W,
   parameter int RD_LAT      = 2,
   parameter int SWEEP_DEPTH = 2048
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   input  logic              sweep_start,
   input  logic [DATA_W-1:0] sweep_data,
   output logic              busy,
   output logic              sweep_done,
   output logic              PL_INIT,
   output logic              PL_ENA,
   output logic              PL_WEN,
   output logic              PL_REN,
   output logic [ADDR_W-1:0] PL_ADDR,
   output logic [DATA_W-1:0] PL_DATA_IN,
   input  logic [DATA_W-1:0] PL_DATA_OUT
);

   localparam int CNT_W = pl_cnt_w(SWEEP_DEPTH, RD_LAT);
   localparam logic [CNT_W-1:0] RW_LOAD = (RD_LAT > 1) ? CNT_W'(RD_LAT - 2) : '0;
   localparam logic [CNT_W-1:0] SW_LAST = CNT_W'(SWEEP_DEPTH - 1);

   pl_state_t         state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              req_ready_q;
   logic              busy_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              sweep_done_q;
   logic              pl_init_q;
   logic              pl_ena_q;
   logic              pl_wen_q;
   logic              pl_ren_q;
   logic [ADDR_W-1:0] pl_addr_q;
   logic [DATA_W-1:0] pl_din_q;

   // Sequencer: every output is the registered image of the state being entered.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         sweep_done_q <= 1'b0;
         pl_init_q    <= 1'b0;
         pl_ena_q     <= 1'b0;
         pl_wen_q     <= 1'b0;
         pl_ren_q     <= 1'b0;
         pl_addr_q    <= '0;
         pl_din_q     <= '0;
      end else begin
         sweep_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sweep_start) begin
                  state_q     <= SWEEP;
                  cnt_q       <= '0;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  pl_init_q   <= 1'b1;
                  pl_ena_q    <= 1'b1;
                  pl_wen_q    <= 1'b1;
                  pl_addr_q   <= '0;
                  pl_din_q    <= sweep_data;
               end else if (req_valid) begin
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  pl_ena_q    <= 1'b1;
                  pl_addr_q   <= req_addr;
                  if (req_we) begin
                     state_q  <= WRITE;
                     pl_wen_q <= 1'b1;
                     pl_din_q <= req_wdata;
                  end else begin
                     state_q  <= READ;
                     pl_ren_q <= 1'b1;
                  end
               end else begin
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            WRITE: begin
               state_q     <= IDLE;
               pl_ena_q    <= 1'b0;
               pl_wen_q    <= 1'b0;
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            READ: begin
               pl_ren_q <= 1'b0;
               if (RD_LAT == 1) begin
                  state_q  <= RESP;
                  pl_ena_q <= 1'b0;
               end else begin
                  state_q <= RWAIT;
                  cnt_q   <= RW_LOAD;
               end
            end
            RWAIT: begin
               if (cnt_q == '0) begin
                  state_q  <= RESP;
                  pl_ena_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            RESP: begin
               // First RESP cycle is the data-valid cycle; capture, then hold until taken.
               if (!rsp_valid_q) begin
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= PL_DATA_OUT;
               end else if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else begin
                  rsp_valid_q <= 1'b1;
               end
            end
            SWEEP: begin
               if (cnt_q == SW_LAST) begin
                  state_q      <= IDLE;
                  pl_init_q    <= 1'b0;
                  pl_ena_q     <= 1'b0;
                  pl_wen_q     <= 1'b0;
                  sweep_done_q <= 1'b1;
                  req_ready_q  <= 1'b1;
                  busy_q       <= 1'b0;
               end else begin
                  cnt_q     <= cnt_q + CNT_W'(1);
                  pl_addr_q <= ADDR_W'(cnt_q + CNT_W'(1));
               end
            end
            default: begin
               state_q     <= IDLE;
               pl_init_q   <= 1'b0;
               pl_ena_q    <= 1'b0;
               pl_wen_q    <= 1'b0;
               pl_ren_q    <= 1'b0;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign busy       = busy_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign sweep_done = sweep_done_q;
   assign PL_INIT    = pl_init_q;
   assign PL_ENA     = pl_ena_q;
   assign PL_WEN     = pl_wen_q;
   assign PL_REN     = pl_ren_q;
   assign PL_ADDR    = pl_addr_q;
   assign PL_DATA_IN = pl_din_q;

endmodule

// File: tb/tb_ram_pl_master.sv
// Self-checking bench for ram_pl_master: directed plan items plus randomized
// transactions checked against a cycle timeline derived from the protocol rules.
module tb_ram_pl_master;
   import ql_pl_pkg::*;

   localparam int AW = 20;
   localparam int DW = 32;
   localparam int RL = 2;
   localparam int SD = 8;

   logic          CLK = 1'b0;
   logic          CLR = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          sweep_start = 1'b0;
   logic [DW-1:0] sweep_data = '0;
   logic          busy;
   logic          sweep_done;
   logic          PL_INIT, PL_ENA, PL_WEN, PL_REN;
   logic [AW-1:0] PL_ADDR;
   logic [DW-1:0] PL_DATA_IN;
   logic [DW-1:0] PL_DATA_OUT = '0;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int ren_cyc = -100;
   logic [AW-1:0] ren_addr = '0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_din = '0;

   ram_pl_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .SWEEP_DEPTH(SD)) dut (
      .CLK(CLK), .CLR(CLR),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .sweep_start(sweep_start), .sweep_data(sweep_data),
      .busy(busy), .sweep_done(sweep_done),
      .PL_INIT(PL_INIT), .PL_ENA(PL_ENA), .PL_WEN(PL_WEN), .PL_REN(PL_REN),
      .PL_ADDR(PL_ADDR), .PL_DATA_IN(PL_DATA_IN), .PL_DATA_OUT(PL_DATA_OUT)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc = cyc + 1;

   // Memory model: data is valid only in the cycle RL after the PL_REN cycle.
   function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
      return 32'hA5A5_0000 | DW'(a);
   endfunction

   always @(negedge CLK) begin
      if (PL_REN === 1'b1) begin
         ren_cyc  = cyc;
         ren_addr = PL_ADDR;
      end
      PL_DATA_OUT = (cyc == ren_cyc + RL) ? rd_pat(ren_addr) : DW'($urandom);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] stb();
      return {PL_INIT, PL_ENA, PL_WEN, PL_REN};
   endfunction

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".stb"}, 64'(stb()), 64'h0);
      chk({tag, ".busy"}, 64'(busy), 64'h0);
      chk({tag, ".rdy"}, 64'(req_ready), 64'h1);
      chk({tag, ".rspv"}, 64'(rsp_valid), 64'h0);
      chk({tag, ".done"}, 64'(sweep_done), 64'h0);
      chk({tag, ".addr"}, 64'(PL_ADDR), 64'(exp_addr));
      chk({tag, ".din"}, 64'(PL_DATA_IN), 64'(exp_din));
   endtask

   task automatic do_write(input pl_req_t r);
      req_valid = 1'b1; req_we = 1'b1; req_addr = r.addr; req_wdata = r.wdata;
      tick();
      req_valid = 1'b0; req_addr = AW'($urandom); req_wdata = DW'($urandom);
      chk("wr.stb", 64'(stb()), 64'h6);
      chk("wr.addr", 64'(PL_ADDR), 64'(r.addr));
      chk("wr.din", 64'(PL_DATA_IN), 64'(r.wdata));
      chk("wr.rdy", 64'(req_ready), 64'h0);
      chk("wr.busy", 64'(busy), 64'h1);
      exp_addr = r.addr; exp_din = r.wdata;
      tick();
      chk_idle("wr.end");
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int stall);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b0;
      tick();
      req_valid = 1'b0; req_addr = AW'($urandom);
      chk("rd.stb", 64'(stb()), 64'h5);
      chk("rd.addr", 64'(PL_ADDR), 64'(a));
      chk("rd.busy", 64'(busy), 64'h1);
      exp_addr = a;
      for (int i = 1; i < RL; i++) begin
         sweep_start = 1'($urandom);
         tick();
         chk("rwait.stb", 64'(stb()), 64'h4);
         chk("rwait.rspv", 64'(rsp_valid), 64'h0);
      end
      sweep_start = 1'($urandom);
      tick();
      chk("cap.stb", 64'(stb()), 64'h0);
      chk("cap.rspv", 64'(rsp_valid), 64'h0);
      chk("cap.busy", 64'(busy), 64'h1);
      tick();
      chk("rsp.valid", 64'(rsp_valid), 64'h1);
      chk("rsp.data", 64'(rsp_rdata), 64'(rd_pat(a)));
      for (int i = 0; i < stall; i++) begin
         sweep_start = 1'($urandom);
         req_valid = 1'($urandom);
         tick();
         chk("stall.valid", 64'(rsp_valid), 64'h1);
         chk("stall.data", 64'(rsp_rdata), 64'(rd_pat(a)));
         chk("stall.rdy", 64'(req_ready), 64'h0);
         chk("stall.stb", 64'(stb()), 64'h0);
      end
      sweep_start = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk_idle("rd.end");
   endtask

   task automatic do_sweep(input logic [DW-1:0] pat, input logic with_req, input pl_req_t r);
      sweep_start = 1'b1; sweep_data = pat;
      if (with_req) begin
         req_valid = 1'b1; req_we = r.we; req_addr = r.addr; req_wdata = r.wdata;
      end
      tick();
      sweep_start = 1'b0; sweep_data = DW'($urandom);
      for (int i = 0; i < SD; i++) begin
         chk("sw.stb", 64'(stb()), 64'hE);
         chk("sw.addr", 64'(PL_ADDR), 64'(i));
         chk("sw.din", 64'(PL_DATA_IN), 64'(pat));
         chk("sw.rdy", 64'(req_ready), 64'h0);
         chk("sw.done", 64'(sweep_done), 64'h0);
         tick();
      end
      chk("swend.stb", 64'(stb()), 64'h0);
      chk("swend.done", 64'(sweep_done), 64'h1);
      chk("swend.rdy", 64'(req_ready), 64'h1);
      chk("swend.busy", 64'(busy), 64'h0);
      exp_addr = AW'(SD - 1); exp_din = pat;
      tick();
      if (with_req) begin
         req_valid = 1'b0;
         chk("swreq.stb", 64'(stb()), 64'h6);
         chk("swreq.addr", 64'(PL_ADDR), 64'(r.addr));
         chk("swreq.din", 64'(PL_DATA_IN), 64'(r.wdata));
         chk("swreq.done", 64'(sweep_done), 64'h0);
         exp_addr = r.addr; exp_din = r.wdata;
         tick();
      end
      chk_idle("sw.after");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pl_req_t r;
      int op;
      // Reset held three cycles
      tick();
      chk("rst.stb", 64'(stb()), 64'h0);
      tick();
      tick();
      CLR = 1'b0;
      #1;
      chk_idle("rst");
      tick();

      r.we = 1'b1; r.addr = 20'h00123; r.wdata = 32'hDEAD_BEEF;
      do_write(r);
      do_read(20'h00040, 0);
      do_read(20'h00077, 5);
      r.we = 1'b1; r.addr = 20'h00999; r.wdata = 32'h1234_5678;
      do_sweep(32'h0, 1'b1, r);

      // Abort during RWAIT
      req_valid = 1'b1; req_we = 1'b0; req_addr = 20'h00055;
      tick();
      req_valid = 1'b0;
      tick();
      chk("abrd.pre", 64'(stb()), 64'h4);
      #1 CLR = 1'b1;
      #1;
      chk("abrd.stb", 64'(stb()), 64'h0);
      chk("abrd.busy", 64'(busy), 64'h0);
      tick();
      CLR = 1'b0;
      exp_addr = '0; exp_din = '0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_idle("abrd.after");
      end

      // Abort mid-sweep at address 3
      sweep_start = 1'b1; sweep_data = 32'hCAFE_F00D;
      tick();
      sweep_start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("absw.addr", 64'(PL_ADDR), 64'h3);
      chk("absw.pre", 64'(stb()), 64'hE);
      #1 CLR = 1'b1;
      #1;
      chk("absw.stb", 64'(stb()), 64'h0);
      chk("absw.done", 64'(sweep_done), 64'h0);
      tick();
      CLR = 1'b0;
      exp_addr = '0; exp_din = '0;
      for (int i = 0; i < SD + 2; i++) begin
         tick();
         chk_idle("absw.after");
      end

      // Randomized mix
      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(0, 9));
         r.we = 1'b1; r.addr = AW'($urandom); r.wdata = DW'($urandom);
         if (op < 5) do_write(r);
         else if (op < 9) do_read(r.addr, int'($urandom_range(0, 3)));
         else do_sweep(DW'($urandom), 1'($urandom), r);
         for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
            tick();
            chk_idle("gap");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_pl_master.md
Name: ram_pl_master

Overview:
- Initiator for the RAM macro's PL (preload/programming) side port, which the RAM wrapper ties off in normal use.
- Accepts single-word read/write requests over a valid/ready interface and sequences PL_ENA/PL_WEN/PL_REN/PL_ADDR/PL_DATA_IN.
- Captures PL_DATA_OUT after the fixed read latency and returns it on a response handshake.
- Also runs a self-timed fill sweep, with PL_INIT asserted, for RAM initialisation after configuration.

Parameters:
- ADDR_W, 20, PL_ADDR width.
- DATA_W, 32, PL data width.
- RD_LAT, 2, cycles from the PL_REN cycle to PL_DATA_OUT valid; legal values are 1 or more.
- SWEEP_DEPTH, 2048, number of words written by a sweep, at addresses 0 to SWEEP_DEPTH-1.

Ports:
- CLK  in  1  clock; PL_CLK is driven from the same net at top level, not by this block.
- CLR  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target PL address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data.
- sweep_start  in  1  start-fill request, level-sampled in IDLE.
- sweep_data  in  DATA_W  fill pattern.
- busy  out  1  state != IDLE.
- sweep_done  out  1  one-cycle pulse at end of sweep.
- PL_INIT, PL_ENA, PL_WEN, PL_REN  out  1 each  PL strobes.
- PL_ADDR  out  ADDR_W  PL address.
- PL_DATA_IN  out  DATA_W  PL write data.
- PL_DATA_OUT  in  DATA_W  PL read data.

Behaviour:
- All outputs are driven from flops; there is no combinational path from any input to any output.
- States: IDLE, WRITE, READ, RWAIT, RESP, SWEEP.
- CLR (async) puts the state in IDLE and clears to 0: all strobes, PL_ADDR, PL_DATA_IN, rsp_valid, rsp_rdata, sweep_done, busy, and the counters. req_ready = 1 in IDLE, including directly out of reset.
- IDLE arbitration:
  - sweep_start has priority over req_valid in the same cycle: the request is not accepted (req_ready is dropped next cycle) and the sweep starts.
  - sweep_start in any other state is ignored.
- Write, accepted in cycle t:
  - Cycle t+1 is WRITE: PL_ENA=1, PL_WEN=1, PL_ADDR=req_addr, PL_DATA_IN=req_wdata, req_ready=0.
  - Cycle t+2 returns to IDLE. Maximum throughput is one write per 2 cycles.
- Read, accepted in cycle t:
  - Cycle t+1 is READ: PL_ENA=1, PL_REN=1, PL_ADDR=req_addr.
  - RWAIT follows for RD_LAT-1 cycles with PL_ENA=1 and PL_REN=0; RD_LAT=1 skips RWAIT.
  - PL_DATA_OUT is sampled at the end of cycle t+1+RD_LAT.
  - RESP starts in cycle t+2+RD_LAT: rsp_valid=1, rsp_rdata stable until rsp_valid && rsp_ready, then IDLE.
  - A response is never lost or duplicated.
- Sweep:
  - sweep_data is captured on the start cycle.
  - SWEEP lasts exactly SWEEP_DEPTH cycles with PL_INIT=1, PL_ENA=1, PL_WEN=1. PL_ADDR = counter zero-extended to ADDR_W, counting 0 to SWEEP_DEPTH-1. PL_DATA_IN = captured pattern.
  - On the cycle after the last word, all strobes = 0, sweep_done=1 for one cycle, and the state returns to IDLE.
- Invariants:
  - PL_WEN and PL_REN are never both 1.
  - PL_INIT=1 only in SWEEP.
  - Outside WRITE/READ/RWAIT/SWEEP, all strobes are 0, and PL_ADDR/PL_DATA_IN hold their last value.
- CLR mid-operation: immediate abort. A pending read response is discarded, an in-progress sweep produces no sweep_done, and the strobes drop asynchronously.
- busy = 1 in every state except IDLE.

Decomposition:
- Package ql_pl_pkg holds:
  - the state enum pl_state_t;
  - PL_ADDR_W=20 and PL_DATA_W=32;
  - a pl_req_t struct of {we, addr, wdata}.
- No sub-module is needed: a single FSM plus one shared counter, reused for RWAIT latency and the sweep address.

Test Plan:
- Reset: hold CLR high for 3 cycles, then release -> all PL outputs 0, rsp_valid=0, busy=0, req_ready=1 on the first cycle after release.
- Write: req_we=1, addr=0x00123, wdata=0xDEADBEEF, accepted at t -> at t+1 exactly one cycle of PL_ENA=PL_WEN=1 with PL_ADDR=0x00123, PL_DATA_IN=0xDEADBEEF; req_ready=1 again at t+2.
- Read with RD_LAT=2 and a memory model returning 0xA5A50000|addr: read at addr 0x00040 accepted at t -> PL_REN at t+1 only; rsp_valid rises at t+4 with rsp_rdata=0xA5A50040.
- Back-pressure: hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid and rsp_rdata stay stable, req_ready=0; release -> exactly one handshake, then IDLE.
- Sweep and arbitration: SWEEP_DEPTH=8, sweep_data=0x0, with sweep_start and req_valid asserted in the same cycle -> 8 cycles of PL_INIT/ENA/WEN at addresses 0..7, then a single sweep_done pulse; the request is accepted only afterwards.
- Abort: assert CLR during RWAIT and again mid-sweep (address 3) -> strobes drop immediately, no rsp_valid, no sweep_done, IDLE after release.
